led_ring_sequencer: RTL

LED_RING_SEQUENCER -- requirements
Module: led_ring_sequencer

---
 rtl/microwave_pkg.sv | 17 +
 rtl/step_prescaler.sv | 38 +++
 rtl/led_ring_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/microwave_pkg.sv
// Shared encodings for the microwave front-panel blocks: sequencer states and
// LED ring animation modes.
package microwave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_HOLD   = 2'd0;
  localparam logic [1:0] MODE_CW     = 2'd1;
  localparam logic [1:0] MODE_CCW    = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

endpackage

// File: rtl/step_prescaler.sv
// Free-running step prescaler: counts 0..STEP_DIV-1 while enabled, holds when
// disabled, and flags the terminal count for one cycle.
module step_prescaler #(
  parameter int STEP_DIV = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o
);

  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST = CW'(STEP_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A clear in the same cycle suppresses the terminal count.
  assign tc_o = en_i && !clr_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_ring_sequencer.sv
// LED ring animation sequencer for the cook cycle: drives the 4-to-16 decoder
// index plus run/idle enables, with a blinking finish phase.
module led_ring_sequencer
  import microwave_pkg::*;
#(
  parameter int STEP_DIV   = 25_000_000,
  parameter int DONE_STEPS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       done,
  input  logic [1:0] mode,
  output logic [3:0] I,
  output logic       run,
  output logic       idle,
  output logic       step
);

  localparam int DW = $clog2(DONE_STEPS + 1);
  localparam logic [DW-1:0] DONE_LAST = DW'(DONE_STEPS - 1);

  state_e        state_q, state_d;
  logic [3:0]    i_q, i_d;
  logic          dir_up_q, dir_up_d;
  logic          blink_q, blink_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic          run_q, run_d;
  logic          idle_q, idle_d;
  logic          step_q, step_d;
  logic          pre_en, pre_clr, tc;
  logic [4:0]    bnc;

  // Returns {dir_up, index}: reflects off both ends of the ring.
  function automatic logic [4:0] bounce_next(input logic [3:0] idx, input logic up);
    if (up) begin
      if (idx == 4'd15) return {1'b0, 4'd14};
      return {1'b1, idx + 4'd1};
    end
    if (idx == 4'd0) return {1'b1, 4'd1};
    return {1'b0, idx - 4'd1};
  endfunction

  assign pre_en  = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign pre_clr = clear || ((state_q == ST_IDLE) && start);

  step_prescaler #(.STEP_DIV(STEP_DIV)) u_pre (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (pre_en),
    .clr_i (pre_clr),
    .tc_o  (tc)
  );

  always_comb begin
    state_d  = state_q;
    i_d      = i_q;
    dir_up_d = dir_up_q;
    blink_d  = blink_q;
    dcnt_d   = dcnt_q;
    step_d   = 1'b0;
    bnc      = bounce_next(i_q, dir_up_q);

    if (tc) begin
      step_d = 1'b1;
      if (state_q == ST_RUN) begin
        // Any non-bounce step re-arms dir so bounce always starts upward.
        dir_up_d = 1'b1;
        case (mode)
          MODE_CW:     i_d = i_q + 4'd1;
          MODE_CCW:    i_d = i_q - 4'd1;
          MODE_BOUNCE: {dir_up_d, i_d} = bnc;
          default:     i_d = i_q;
        endcase
      end else begin
        blink_d = ~blink_q;
        dcnt_d  = dcnt_q + DW'(1);
      end
    end

    if (clear) begin
      state_d  = ST_IDLE;
      i_d      = 4'd0;
      dir_up_d = 1'b1;
      blink_d  = 1'b0;
      dcnt_d   = '0;
    end else if (done && (state_q == ST_RUN || state_q == ST_PAUSE)) begin
      state_d = ST_DONE;
      blink_d = 1'b0;
      dcnt_d  = '0;
    end else if (pause && state_q == ST_RUN) begin
      state_d = ST_PAUSE;
    end else if (start && (state_q == ST_IDLE || state_q == ST_PAUSE)) begin
      state_d = ST_RUN;
    end else if (state_q == ST_DONE && tc && dcnt_q == DONE_LAST) begin
      state_d = ST_IDLE;
      blink_d = 1'b0;
      dcnt_d  = '0;
    end

    case (state_d)
      ST_RUN, ST_PAUSE: run_d = 1'b1;
      ST_DONE:          run_d = blink_d;
      default:          run_d = 1'b0;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      i_q      <= 4'd0;
      dir_up_q <= 1'b1;
      blink_q  <= 1'b0;
      dcnt_q   <= '0;
      run_q    <= 1'b0;
      idle_q   <= 1'b1;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      dir_up_q <= dir_up_d;
      blink_q  <= blink_d;
      dcnt_q   <= dcnt_d;
      run_q    <= run_d;
      idle_q   <= idle_d;
      step_q   <= step_d;
    end
  end

  assign I    = i_q;
  assign run  = run_q;
  assign idle = idle_q;
  assign step = step_q;

endmodule
